armleocpu_cache_port_arbiter: RTL and testbench
===============================================

// Module: armleocpu_cache_port_arbiter
// PURPOSE
//  Shares the single cache command port between instruction fetch (F) and the
//  execute-stage load/store unit (D). Picks one requester whenever the cache can
//  accept a command and passes its command through with no added latency. Routes
//  c_response to the owner of the in-flight command. Sits between fetch/execute
//  and armleocpu_cache.
// PARAMETERS
//  STARVE_LIMIT  4  max consecutive D grants while F is requesting; next grant goes to F
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   reset, synchronous, active-low
//  f_cmd          in   4   fetch command (CACHE_CMD_*; EXECUTE or FLUSH_ALL)
//  f_address      in   32  fetch address
//  f_response     out  4   response seen by fetch (CACHE_RESPONSE_*)
//  d_cmd          in   4   data command (CACHE_CMD_*)
//  d_address      in   32  data address
//  d_load_type    in   3   load type per ld_type.vh
//  d_store_type   in   2   store type per st_type.vh
//  d_store_data   in   32  store data
//  d_response     out  4   response seen by execute
//  c_cmd          out  4   command to cache
//  c_address      out  32  address to cache
//  c_load_type    out  3   load type to cache (LW when F granted)
//  c_store_type   out  2   store type to cache (0 when F granted)
//  c_store_data   out  32  store data to cache (0 when F granted)
//  c_response     in   4   cache response
//  c_load_data    in   32  cache load data; broadcast to both requesters externally
// BEHAVIOUR
//  - accept = c_response in {IDLE, DONE, ACCESSFAULT, MISSALIGNED, PAGEFAULT}.
//    During WAIT the cache ignores c_cmd; arbiter drives c_cmd=NONE.
//  - State: owner in {NONE, F, D} (register); d_streak counter, $clog2(STARVE_LIMIT+1) bits.
//  - Grant (combinational, only when accept): only one requester cmd!=NONE -> it.
//    Both -> D, unless d_streak==STARVE_LIMIT -> F. Grantee's cmd/address/types
//    drive c_* in the same cycle. No grant -> c_cmd=NONE, c_address=f_address.
//  - Next owner: grantee if granted; else NONE when accept; else unchanged (WAIT).
//  - d_streak: +1 on D grant while f_cmd!=NONE, saturating at STARVE_LIMIT.
//    Cleared on F grant or when f_cmd==NONE.
//  - Response routing (combinational):
//    owner's response = c_response.
//    Non-owner while owner!=NONE = WAIT.
//    owner==NONE: both see c_response (IDLE).
//    Requester with cmd!=NONE that lost arbitration in an accept cycle sees WAIT
//    instead of IDLE, so it holds its command. Rule: a requester keeps cmd and
//    address stable until it has a grant.
//  - DONE/error cycle with back-to-back grant: the DONE/error goes to the old owner
//    and the new grantee becomes owner. If both are the same requester, that
//    requester sees the DONE and its new command is accepted that cycle
//    (fetch streaming).
//  - FLUSH_ALL is arbitrated like any command. While it is in flight the other
//    requester sees WAIT.
//  - Reset (rst_n=0 at posedge): owner=NONE, d_streak=0.
//    While rst_n=0: c_cmd=NONE; f_response and d_response = c_response.
//    Reset mid-transaction drops ownership; the cache is reset alongside.
//  - Outputs are combinational from the registers and inputs. No extra latency.
//    No combinational path from c_response to c_cmd except through accept.
// STRUCTURE
//  - CACHE_CMD_*, CACHE_RESPONSE_* from armleocpu_cache.vh; LW from ld_type.vh.
//  - New owner encodings ARMLEOCPU_ARB_OWNER_{NONE,F,D} (2 bits) go in a shared
//    armleocpu_arbiter.vh for reuse by a future PTW/cache arbiter.
//  - Single flat module, no sub-modules.
// TESTING
//  1 Only F: f_cmd=EXECUTE @0x2000, c_response IDLE -> c_cmd=EXECUTE,
//    c_address=0x2000, c_load_type=LW; 2 WAIT cycles then DONE -> f_response
//    WAIT,WAIT,DONE; d_response WAIT,WAIT,WAIT.
//  2 Collision: F and D request in an IDLE cycle, d_streak=0 -> D granted,
//    f_response=WAIT. On D's DONE the held F command is granted in the same cycle.
//  3 Starvation, STARVE_LIMIT=4: D requests back-to-back, F requests continuously
//    -> 4 D grants, then the 5th grant goes to F, then d_streak=0 and D wins again.
//  4 Fault routing: D load @0x1001 -> cache MISSALIGNED -> d_response=MISSALIGNED,
//    f_response=WAIT that cycle, owner=NONE afterwards.
//  5 FLUSH_ALL from F while D requests -> D sees WAIT until flush DONE, then D
//    is granted in the DONE cycle.
//  6 rst_n=0 during WAIT with owner=D -> c_cmd=NONE. After release owner=NONE and
//    an F request is granted at the first IDLE.

Source files
------------

// File: rtl/armleocpu_cache_port_arbiter_pkg.sv
// Shared definitions for the cache command port arbiter: cache command and
// response encodings, load/store type constants, and arbiter owner encodings.
// Combinational helpers only; no state, no flow control of its own.
package armleocpu_cache_port_arbiter_pkg;

    // Cache command encodings (mirror armleocpu_cache.vh)
    localparam logic [3:0] CACHE_CMD_NONE      = 4'd0;
    localparam logic [3:0] CACHE_CMD_EXECUTE   = 4'd1;
    localparam logic [3:0] CACHE_CMD_LOAD      = 4'd2;
    localparam logic [3:0] CACHE_CMD_STORE     = 4'd3;
    localparam logic [3:0] CACHE_CMD_FLUSH_ALL = 4'd4;

    // Cache response encodings (mirror armleocpu_cache.vh)
    localparam logic [3:0] CACHE_RESPONSE_IDLE        = 4'd0;
    localparam logic [3:0] CACHE_RESPONSE_WAIT        = 4'd1;
    localparam logic [3:0] CACHE_RESPONSE_DONE        = 4'd2;
    localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT = 4'd3;
    localparam logic [3:0] CACHE_RESPONSE_PAGEFAULT   = 4'd4;
    localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED = 4'd5;

    // Load type used for instruction fetch (mirror ld_type.vh)
    localparam logic [2:0] LW = 3'b010;

    // Owner of the in-flight cache command; reusable by other port arbiters
    typedef enum logic [1:0] {
        ARMLEOCPU_ARB_OWNER_NONE = 2'd0,
        ARMLEOCPU_ARB_OWNER_F    = 2'd1,
        ARMLEOCPU_ARB_OWNER_D    = 2'd2
    } arb_owner_t;

    // The cache samples c_cmd only in cycles where its response is not WAIT
    // (and not any other busy/unknown code).
    function automatic logic cache_accepts(input logic [3:0] resp);
        return (resp == CACHE_RESPONSE_IDLE)        ||
               (resp == CACHE_RESPONSE_DONE)        ||
               (resp == CACHE_RESPONSE_ACCESSFAULT) ||
               (resp == CACHE_RESPONSE_MISSALIGNED) ||
               (resp == CACHE_RESPONSE_PAGEFAULT);
    endfunction

endpackage

// File: rtl/armleocpu_cache_port_arbiter.sv
// Shares the single cache command port between fetch (F) and load/store (D).
// Latency: grantee's command reaches c_* in the same cycle (zero added latency).
// Backpressure: losers and non-owners see WAIT and must hold cmd/address until granted.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   f_cmd/f_address            fetch request; f_response back to fetch
//   d_cmd/d_address/d_*_type/  load/store request; d_response back to execute
//   d_store_data
//   c_cmd/c_address/c_*_type/  command to the cache
//   c_store_data
//   c_response                 cache response (also decides when a command is accepted)
//   c_load_data                broadcast to requesters outside this block
module armleocpu_cache_port_arbiter
    import armleocpu_cache_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [3:0]  f_cmd,
    input  logic [31:0] f_address,
    output logic [3:0]  f_response,

    input  logic [3:0]  d_cmd,
    input  logic [31:0] d_address,
    input  logic [2:0]  d_load_type,
    input  logic [1:0]  d_store_type,
    input  logic [31:0] d_store_data,
    output logic [3:0]  d_response,

    output logic [3:0]  c_cmd,
    output logic [31:0] c_address,
    output logic [2:0]  c_load_type,
    output logic [1:0]  c_store_type,
    output logic [31:0] c_store_data,
    input  logic [3:0]  c_response,
    input  logic [31:0] c_load_data
);

    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    arb_owner_t          owner_q, owner_d;
    logic [STREAK_W-1:0] d_streak_q, d_streak_d;

    logic accept;
    logic f_req, d_req;
    logic grant_f, grant_d;

    // Load data is fanned out to both requesters outside this block.
    logic unused_c_load_data;
    assign unused_c_load_data = ^c_load_data;

    assign accept = cache_accepts(c_response);
    assign f_req  = (f_cmd != CACHE_CMD_NONE);
    assign d_req  = (d_cmd != CACHE_CMD_NONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q    <= ARMLEOCPU_ARB_OWNER_NONE;
            d_streak_q <= '0;
        end else begin
            owner_q    <= owner_d;
            d_streak_q <= d_streak_d;
        end
    end

    always_comb begin
        owner_d      = owner_q;
        d_streak_d   = d_streak_q;
        grant_f      = 1'b0;
        grant_d      = 1'b0;
        c_cmd        = CACHE_CMD_NONE;
        c_address    = f_address;
        c_load_type  = LW;
        c_store_type = 2'b00;
        c_store_data = 32'h0;
        f_response   = c_response;
        d_response   = c_response;

        if (rst_n) begin
            // D normally wins collisions; F is forced through once D has
            // taken STARVE_LIMIT grants in a row while F was waiting.
            if (accept) begin
                if (f_req && (!d_req || (d_streak_q == STREAK_MAX))) begin
                    grant_f = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end
            end

            if (grant_f) begin
                c_cmd     = f_cmd;
                c_address = f_address;
            end else if (grant_d) begin
                c_cmd        = d_cmd;
                c_address    = d_address;
                c_load_type  = d_load_type;
                c_store_type = d_store_type;
                c_store_data = d_store_data;
            end

            if (grant_f) begin
                owner_d = ARMLEOCPU_ARB_OWNER_F;
            end else if (grant_d) begin
                owner_d = ARMLEOCPU_ARB_OWNER_D;
            end else if (accept) begin
                owner_d = ARMLEOCPU_ARB_OWNER_NONE;
            end

            if (!f_req || grant_f) begin
                d_streak_d = '0;
            end else if (grant_d && (d_streak_q != STREAK_MAX)) begin
                d_streak_d = d_streak_q + 1'b1;
            end

            // The in-flight command's response (including DONE/error on a
            // back-to-back handover) goes to the current owner only.
            case (owner_q)
                ARMLEOCPU_ARB_OWNER_F: d_response = CACHE_RESPONSE_WAIT;
                ARMLEOCPU_ARB_OWNER_D: f_response = CACHE_RESPONSE_WAIT;
                default: ;
            endcase

            // A requester that lost this cycle's arbitration must not read
            // IDLE as "command taken"; WAIT keeps it holding its request.
            if (accept && f_req && !grant_f && (f_response == CACHE_RESPONSE_IDLE)) begin
                f_response = CACHE_RESPONSE_WAIT;
            end
            if (accept && d_req && !grant_d && (d_response == CACHE_RESPONSE_IDLE)) begin
                d_response = CACHE_RESPONSE_WAIT;
            end
        end
    end

endmodule

// File: tb/tb_armleocpu_cache_port_arbiter.sv
module tb_armleocpu_cache_port_arbiter;
    import armleocpu_cache_port_arbiter_pkg::*;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  f_cmd;
    logic [31:0] f_address;
    logic [3:0]  f_response;
    logic [3:0]  d_cmd;
    logic [31:0] d_address;
    logic [2:0]  d_load_type;
    logic [1:0]  d_store_type;
    logic [31:0] d_store_data;
    logic [3:0]  d_response;
    logic [3:0]  c_cmd;
    logic [31:0] c_address;
    logic [2:0]  c_load_type;
    logic [1:0]  c_store_type;
    logic [31:0] c_store_data;
    logic [3:0]  c_response;
    logic [31:0] c_load_data;

    armleocpu_cache_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_cmd(f_cmd), .f_address(f_address), .f_response(f_response),
        .d_cmd(d_cmd), .d_address(d_address), .d_load_type(d_load_type),
        .d_store_type(d_store_type), .d_store_data(d_store_data), .d_response(d_response),
        .c_cmd(c_cmd), .c_address(c_address), .c_load_type(c_load_type),
        .c_store_type(c_store_type), .c_store_data(c_store_data),
        .c_response(c_response), .c_load_data(c_load_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who holds the cache (0 none, 1 fetch, 2 data) and how
    // many D grants in a row happened while F was left waiting.
    int          m_owner = 0;
    int          m_streak = 0;
    int          m_gnt;
    logic [3:0]  e_ccmd, e_f, e_d;
    logic [31:0] e_addr, e_sd;
    logic [2:0]  e_lt;
    logic [1:0]  e_st;

    task automatic model_eval();
        bit acc, fr, dr;
        acc = (c_response == CACHE_RESPONSE_IDLE) || (c_response == CACHE_RESPONSE_DONE) ||
              (c_response == CACHE_RESPONSE_ACCESSFAULT) || (c_response == CACHE_RESPONSE_PAGEFAULT) ||
              (c_response == CACHE_RESPONSE_MISSALIGNED);
        fr = (f_cmd != 4'd0);
        dr = (d_cmd != 4'd0);
        m_gnt = 0;
        if (rst_n && acc) begin
            if (fr && dr)  m_gnt = (m_streak >= LIM) ? 1 : 2;
            else if (fr)   m_gnt = 1;
            else if (dr)   m_gnt = 2;
        end
        e_ccmd = 4'd0; e_addr = f_address; e_lt = LW; e_st = 2'd0; e_sd = 32'd0;
        if (m_gnt == 1) e_ccmd = f_cmd;
        if (m_gnt == 2) begin
            e_ccmd = d_cmd; e_addr = d_address; e_lt = d_load_type;
            e_st = d_store_type; e_sd = d_store_data;
        end
        e_f = c_response;
        e_d = c_response;
        if (rst_n) begin
            if (m_owner == 1) e_d = CACHE_RESPONSE_WAIT;
            if (m_owner == 2) e_f = CACHE_RESPONSE_WAIT;
            if (acc && fr && m_gnt != 1 && e_f == CACHE_RESPONSE_IDLE) e_f = CACHE_RESPONSE_WAIT;
            if (acc && dr && m_gnt != 2 && e_d == CACHE_RESPONSE_IDLE) e_d = CACHE_RESPONSE_WAIT;
        end
    endtask

    // Evaluate outputs mid-cycle, away from the clock edge.
    task automatic settle();
        @(negedge clk);
        model_eval();
        chk("c_cmd", c_cmd, e_ccmd);
        chk("c_address", c_address, e_addr);
        if (m_gnt != 0) begin
            chk("c_load_type", c_load_type, e_lt);
            chk("c_store_type", c_store_type, e_st);
            chk("c_store_data", c_store_data, e_sd);
        end
        chk("f_response", f_response, e_f);
        chk("d_response", d_response, e_d);
    endtask

    task automatic tick();
        bit acc;
        @(posedge clk);
        acc = (c_response != CACHE_RESPONSE_WAIT) && (c_response <= CACHE_RESPONSE_MISSALIGNED);
        if (!rst_n) begin
            m_owner = 0;
            m_streak = 0;
        end else begin
            if (m_gnt != 0)  m_owner = m_gnt;
            else if (acc)    m_owner = 0;
            if (f_cmd == 4'd0 || m_gnt == 1) m_streak = 0;
            else if (m_gnt == 2 && m_streak < LIM) m_streak = m_streak + 1;
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    int  busy, cnt, g;
    bit  f_pend, d_pend;
    logic [3:0] term;

    initial begin
        rst_n = 1'b0; c_response = CACHE_RESPONSE_IDLE; c_load_data = 32'h0;
        f_cmd = CACHE_CMD_EXECUTE; f_address = 32'h100;
        d_cmd = CACHE_CMD_NONE; d_address = 0; d_load_type = 0; d_store_type = 0; d_store_data = 0;

        // Reset: no command reaches the cache, responses pass straight through
        settle();
        chk("rst_c_cmd", c_cmd, CACHE_CMD_NONE);
        chk("rst_f_resp", f_response, CACHE_RESPONSE_IDLE);
        tick();
        rst_n = 1'b1; f_cmd = CACHE_CMD_NONE;
        cyc();

        // 1: fetch alone, two WAIT cycles then DONE
        f_cmd = CACHE_CMD_EXECUTE; f_address = 32'h2000;
        settle();
        chk("t1_cmd", c_cmd, CACHE_CMD_EXECUTE);
        chk("t1_addr", c_address, 32'h2000);
        chk("t1_lt", c_load_type, LW);
        tick();
        f_cmd = CACHE_CMD_NONE; c_response = CACHE_RESPONSE_WAIT;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t1_f_wait", f_response, CACHE_RESPONSE_WAIT);
            chk("t1_d_wait", d_response, CACHE_RESPONSE_WAIT);
            tick();
        end
        c_response = CACHE_RESPONSE_DONE;
        settle();
        chk("t1_f_done", f_response, CACHE_RESPONSE_DONE);
        chk("t1_d_done", d_response, CACHE_RESPONSE_WAIT);
        tick();
        c_response = CACHE_RESPONSE_IDLE;

        // 2: collision with empty streak -> D first, F handed over on D's DONE
        f_cmd = CACHE_CMD_EXECUTE; f_address = 32'h3000;
        d_cmd = CACHE_CMD_LOAD; d_address = 32'h4000; d_load_type = 3'd2;
        settle();
        chk("t2_cmd", c_cmd, CACHE_CMD_LOAD);
        chk("t2_f_lost", f_response, CACHE_RESPONSE_WAIT);
        chk("t2_d_resp", d_response, CACHE_RESPONSE_IDLE);
        tick();
        d_cmd = CACHE_CMD_NONE; c_response = CACHE_RESPONSE_WAIT;
        cyc();
        c_response = CACHE_RESPONSE_DONE;
        settle();
        chk("t2_handover_cmd", c_cmd, CACHE_CMD_EXECUTE);
        chk("t2_handover_addr", c_address, 32'h3000);
        chk("t2_d_done", d_response, CACHE_RESPONSE_DONE);
        chk("t2_f_wait", f_response, CACHE_RESPONSE_WAIT);
        tick();
        f_cmd = CACHE_CMD_NONE;
        settle();
        chk("t2_f_done", f_response, CACHE_RESPONSE_DONE);
        tick();
        c_response = CACHE_RESPONSE_IDLE;
        cyc();

        // 3: starvation guard: 4 D grants, then F, then D again
        f_cmd = CACHE_CMD_EXECUTE; f_address = 32'h5000;
        d_cmd = CACHE_CMD_LOAD; d_address = 32'h5100;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk($sformatf("t3_grant%0d", k), c_cmd, (k == 4) ? CACHE_CMD_EXECUTE : CACHE_CMD_LOAD);
            tick();
            c_response = CACHE_RESPONSE_DONE;
        end
        f_cmd = CACHE_CMD_NONE; d_cmd = CACHE_CMD_NONE;
        cyc();
        c_response = CACHE_RESPONSE_IDLE;
        cyc();

        // 4: misaligned load fault is routed to D only
        d_cmd = CACHE_CMD_LOAD; d_address = 32'h1001;
        cyc();
        d_cmd = CACHE_CMD_NONE; c_response = CACHE_RESPONSE_MISSALIGNED;
        settle();
        chk("t4_d_fault", d_response, CACHE_RESPONSE_MISSALIGNED);
        chk("t4_f_wait", f_response, CACHE_RESPONSE_WAIT);
        tick();
        c_response = CACHE_RESPONSE_IDLE;
        settle();
        chk("t4_f_idle", f_response, CACHE_RESPONSE_IDLE);
        chk("t4_d_idle", d_response, CACHE_RESPONSE_IDLE);
        tick();

        // 5: flush from F blocks D until DONE, D granted in the DONE cycle
        f_cmd = CACHE_CMD_FLUSH_ALL;
        settle();
        chk("t5_flush", c_cmd, CACHE_CMD_FLUSH_ALL);
        tick();
        f_cmd = CACHE_CMD_NONE; c_response = CACHE_RESPONSE_WAIT;
        d_cmd = CACHE_CMD_STORE; d_address = 32'h6000; d_store_type = 2'd2; d_store_data = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t5_d_wait", d_response, CACHE_RESPONSE_WAIT);
            chk("t5_no_cmd", c_cmd, CACHE_CMD_NONE);
            tick();
        end
        c_response = CACHE_RESPONSE_DONE;
        settle();
        chk("t5_store_cmd", c_cmd, CACHE_CMD_STORE);
        chk("t5_store_data", c_store_data, 32'hDEADBEEF);
        chk("t5_f_done", f_response, CACHE_RESPONSE_DONE);
        tick();
        d_cmd = CACHE_CMD_NONE;
        cyc();
        c_response = CACHE_RESPONSE_IDLE;
        cyc();

        // 6: reset while D's command is in flight
        d_cmd = CACHE_CMD_LOAD; d_address = 32'h7000;
        cyc();
        d_cmd = CACHE_CMD_NONE; c_response = CACHE_RESPONSE_WAIT;
        cyc();
        rst_n = 1'b0; f_cmd = CACHE_CMD_EXECUTE; f_address = 32'h8000;
        settle();
        chk("t6_rst_cmd", c_cmd, CACHE_CMD_NONE);
        chk("t6_rst_f", f_response, CACHE_RESPONSE_WAIT);
        tick();
        rst_n = 1'b1; c_response = CACHE_RESPONSE_IDLE;
        settle();
        chk("t6_f_grant", c_cmd, CACHE_CMD_EXECUTE);
        chk("t6_f_idle", f_response, CACHE_RESPONSE_IDLE);
        chk("t6_d_idle", d_response, CACHE_RESPONSE_IDLE);
        tick();
        f_cmd = CACHE_CMD_NONE; c_response = CACHE_RESPONSE_DONE;
        cyc();
        c_response = CACHE_RESPONSE_IDLE;
        cyc();

        // Randomized traffic against a simple cache with variable latency
        busy = 0; cnt = 0; term = CACHE_RESPONSE_DONE; f_pend = 0; d_pend = 0;
        for (int n = 0; n < 3000; n++) begin
            c_response = (busy == 0) ? CACHE_RESPONSE_IDLE :
                         (cnt > 0) ? CACHE_RESPONSE_WAIT : term;
            if (!f_pend && ($urandom % 3 == 0)) begin
                f_pend = 1;
                f_cmd = ($urandom % 8 == 0) ? CACHE_CMD_FLUSH_ALL : CACHE_CMD_EXECUTE;
                f_address = $urandom;
            end
            if (!d_pend && ($urandom % 2 == 0)) begin
                d_pend = 1;
                d_cmd = ($urandom % 2 == 0) ? CACHE_CMD_LOAD : CACHE_CMD_STORE;
                d_address = $urandom;
                d_load_type = 3'($urandom_range(0, 4));
                d_store_type = 2'($urandom_range(0, 2));
                d_store_data = $urandom;
            end
            rst_n = ($urandom % 250 != 0);
            settle();
            g = m_gnt;
            tick();
            if (!rst_n) begin
                busy = 0;
                rst_n = 1'b1;
            end else if (busy != 0) begin
                if (cnt > 0) cnt--; else busy = 0;
            end
            if (g != 0) begin
                busy = 1;
                cnt = $urandom_range(0, 3);
                case ($urandom % 8)
                    0: term = CACHE_RESPONSE_ACCESSFAULT;
                    1: term = CACHE_RESPONSE_PAGEFAULT;
                    2: term = CACHE_RESPONSE_MISSALIGNED;
                    default: term = CACHE_RESPONSE_DONE;
                endcase
            end
            if (g == 1) begin f_pend = 0; f_cmd = CACHE_CMD_NONE; end
            if (g == 2) begin d_pend = 0; d_cmd = CACHE_CMD_NONE; end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
